// File: rtl/ifetch_rv32i.sv
// RV32I instruction fetch stage: credit-limited imem requests, in-order response FIFO,
// redirect flush with stale-response dropping. Optional macro: IFETCH_BYPASS_EN.
module ifetch_rv32i #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        fetch_en,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [6:0]  id_opcode,
  output logic [2:0]  id_funct3,
  output logic [6:0]  id_funct7
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     resp_pc_q, resp_pc_d;
  logic [CW-1:0]   out_q, out_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [31:0]     fifo_pc_q [FIFO_DEPTH];
  logic [31:0]     fifo_pc_d [FIFO_DEPTH];
  logic [31:0]     fifo_instr_q [FIFO_DEPTH];
  logic [31:0]     fifo_instr_d [FIFO_DEPTH];

  logic            pop_s;
  logic            credit_s;
  logic            gnt_s;
  logic            accept_s;
  logic            drop_rv_s;
  logic            bypass_s;
  logic            push_s;
  logic [CW-1:0]   inflight_s;
  logic            unused_addr_lsb_s;

  assign unused_addr_lsb_s = ^redirect_pc[1:0];

  // Handshake and credit terms derived from the registered state.
  always_comb begin
    pop_s      = (cnt_q != '0) && id_ready;
    credit_s   = (({1'b0, out_q} + {1'b0, cnt_q} - (CW+1)'(pop_s)) < DEPTH_W);
    accept_s   = imem_rvalid && (drop_q == '0);
    drop_rv_s  = imem_rvalid && (drop_q != '0);
    inflight_s = drop_q + out_q - CW'(imem_rvalid);
`ifdef IFETCH_BYPASS_EN
    bypass_s   = (cnt_q == '0) && accept_s && !redirect;
`else
    bypass_s   = 1'b0;
`endif
    push_s     = accept_s && !redirect && !(bypass_s && id_ready);
  end

  assign imem_req  = (state_q == RUN) && !redirect && credit_s;
  assign gnt_s     = imem_req && imem_gnt;
  assign imem_addr = fetch_pc_q;

  // A bypassed response is presented directly; otherwise decode sees the FIFO head.
  assign id_valid  = (cnt_q != '0) || bypass_s;
  assign id_instr  = bypass_s ? imem_rdata : fifo_instr_q[rptr_q];
  assign id_pc     = bypass_s ? resp_pc_q  : fifo_pc_q[rptr_q];
  assign id_opcode = id_instr[6:0];
  assign id_funct3 = id_instr[14:12];
  assign id_funct7 = id_instr[31:25];

  // Next-state logic: redirect overrides all normal fetch/response/pop bookkeeping.
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    resp_pc_d    = resp_pc_q;
    out_d        = out_q;
    drop_d       = drop_q;
    cnt_d        = cnt_q;
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    fifo_pc_d    = fifo_pc_q;
    fifo_instr_d = fifo_instr_q;
    if (redirect) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      resp_pc_d  = {redirect_pc[31:2], 2'b00};
      out_d      = '0;
      drop_d     = inflight_s;
      cnt_d      = '0;
      wptr_d     = '0;
      rptr_d     = '0;
      if (inflight_s != '0) begin
        state_d = DRAIN;
      end else if (fetch_en) begin
        state_d = RUN;
      end else begin
        state_d = IDLE;
      end
    end else begin
      if (gnt_s) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end else begin
        fetch_pc_d = fetch_pc_q;
      end
      // resp_pc tracks the address of the oldest live in-flight request.
      if (accept_s) begin
        resp_pc_d = resp_pc_q + 32'd4;
      end else begin
        resp_pc_d = resp_pc_q;
      end
      out_d  = out_q + CW'(gnt_s) - CW'(accept_s);
      drop_d = drop_q - CW'(drop_rv_s);
      if (push_s) begin
        fifo_pc_d[wptr_q]    = resp_pc_q;
        fifo_instr_d[wptr_q] = imem_rdata;
        wptr_d               = wptr_q + AW'(1);
      end else begin
        wptr_d = wptr_q;
      end
      if (pop_s) begin
        rptr_d = rptr_q + AW'(1);
      end else begin
        rptr_d = rptr_q;
      end
      cnt_d = cnt_q + CW'(push_s) - CW'(pop_s);
      case (state_q)
        IDLE:    state_d = fetch_en ? RUN : IDLE;
        RUN:     state_d = fetch_en ? RUN : IDLE;
        DRAIN: begin
          if (drop_d == '0) begin
            state_d = fetch_en ? RUN : IDLE;
          end else begin
            state_d = DRAIN;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      out_q      <= '0;
      drop_q     <= '0;
      cnt_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_pc_q[i]    <= 32'h0000_0000;
        fifo_instr_q[i] <= 32'h0000_0000;
      end
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      resp_pc_q    <= resp_pc_d;
      out_q        <= out_d;
      drop_q       <= drop_d;
      cnt_q        <= cnt_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      fifo_pc_q    <= fifo_pc_d;
      fifo_instr_q <= fifo_instr_d;
    end
  end

endmodule

// File: tb/tb_ifetch_rv32i.sv
// Directed self-checking bench for ifetch_rv32i with a small in-order memory model.
module tb_ifetch_rv32i;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        fetch_en;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [6:0]  id_opcode;
  logic [2:0]  id_funct3;
  logic [6:0]  id_funct7;

  int errors = 0;
  int checks = 0;

  logic        resp_en;
  logic [31:0] pend[$];

  logic        o_req, o_gnt, o_valid, o_take, o_rvalid;
  logic [31:0] o_addr, o_pc, o_instr;
  logic [6:0]  o_opc, o_f7;
  logic [2:0]  o_f3;

  ifetch_rv32i #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clock(clock), .reset_n(reset_n), .fetch_en(fetch_en),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc),
    .id_opcode(id_opcode), .id_funct3(id_funct3), .id_funct7(id_funct7)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  // Instruction memory contents: address 0 holds addi x1,x0,5.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return 32'h0050_0093 ^ {a[9:2], 24'h00_0000} ^ {17'h0_0000, a[4:2], 12'h000};
  endfunction

  // One clock: sample outputs mid-cycle, then model grant capture and 1-cycle responses.
  task automatic step();
    #1;
    o_req    = imem_req;
    o_addr   = imem_addr;
    o_gnt    = imem_req && imem_gnt;
    o_valid  = id_valid;
    o_take   = id_valid && id_ready;
    o_pc     = id_pc;
    o_instr  = id_instr;
    o_opc    = id_opcode;
    o_f3     = id_funct3;
    o_f7     = id_funct7;
    o_rvalid = imem_rvalid;
    @(posedge clock);
    #1;
    if (o_gnt) pend.push_back(o_addr);
    if (resp_en && pend.size() > 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_fn(pend.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
    end
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset_n = 1'b0; fetch_en = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
    imem_rdata = 32'h0; redirect = 1'b0; redirect_pc = 32'h0; id_ready = 1'b0;
    resp_en = 1'b1;
    pend.delete();
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; fetch_en = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
    imem_rdata = 32'h0; redirect = 1'b0; redirect_pc = 32'h0; id_ready = 1'b0;
    #3;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 00000000", imem_addr); end
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", id_valid); end
    checks++; if (id_instr !== 32'h0 || id_pc !== 32'h0) begin errors++; $display("FAIL reset_id: instr %h pc %h want 0/0", id_instr, id_pc); end
    do_reset();
  endtask

  task automatic test_latency();
    bit found;
    logic exp_v;
    do_reset();
    fetch_en = 1'b1; imem_gnt = 1'b1; id_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (o_rvalid) begin found = 1'b1; break; end
    end
    checks++; if (!found) begin errors++; $display("FAIL latency_rvalid: got no response want one within 10 cycles"); end
`ifdef IFETCH_BYPASS_EN
    exp_v = 1'b1;
`else
    exp_v = 1'b0;
`endif
    checks++; if (o_valid !== exp_v) begin errors++; $display("FAIL latency_valid_same_cycle: got %b want %b", o_valid, exp_v); end
`ifndef IFETCH_BYPASS_EN
    step();
`endif
    checks++; if (o_valid !== 1'b1 || o_pc !== 32'h0 || o_instr !== 32'h0050_0093) begin
      errors++; $display("FAIL latency_first: valid %b pc %h instr %h want 1/00000000/00500093", o_valid, o_pc, o_instr); end
    checks++; if (o_opc !== 7'h13 || o_f3 !== 3'h0 || o_f7 !== 7'h00) begin
      errors++; $display("FAIL decode_fields: op %h f3 %h f7 %h want 13/0/00", o_opc, o_f3, o_f7); end
  endtask

  task automatic test_stream();
    logic [31:0] exp_addr, exp_pc, ei;
    int takes;
    do_reset();
    fetch_en = 1'b1; imem_gnt = 1'b1; id_ready = 1'b1;
    exp_addr = 32'h0; exp_pc = 32'h0; takes = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (o_gnt) begin
        checks++; if (o_addr !== exp_addr) begin errors++; $display("FAIL stream_addr: got %h want %h", o_addr, exp_addr); end
        exp_addr = exp_addr + 32'd4;
      end
      if (o_take) begin
        ei = mem_fn(exp_pc);
        checks++; if (o_pc !== exp_pc || o_instr !== ei) begin
          errors++; $display("FAIL stream_data: pc %h instr %h want %h/%h", o_pc, o_instr, exp_pc, ei); end
        checks++; if (o_opc !== ei[6:0] || o_f3 !== ei[14:12] || o_f7 !== ei[31:25]) begin
          errors++; $display("FAIL stream_fields: op %h f3 %h f7 %h want %h/%h/%h", o_opc, o_f3, o_f7, ei[6:0], ei[14:12], ei[31:25]); end
        exp_pc = exp_pc + 32'd4;
        takes++;
      end
    end
    checks++; if (takes < 12) begin errors++; $display("FAIL stream_rate: got %0d takes want >=12", takes); end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_addr, exp_pc;
    int grants;
    do_reset();
    fetch_en = 1'b1; imem_gnt = 1'b1; id_ready = 1'b0;
    grants = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (o_gnt) grants++;
      if (i >= 4) begin
        checks++; if (o_valid !== 1'b1 || o_pc !== 32'h0 || o_instr !== mem_fn(32'h0)) begin
          errors++; $display("FAIL bp_hold: valid %b pc %h instr %h want 1/00000000/%h", o_valid, o_pc, o_instr, mem_fn(32'h0)); end
      end
    end
    checks++; if (grants !== 2) begin errors++; $display("FAIL bp_grants: got %0d want 2", grants); end
    checks++; if (o_req !== 1'b0) begin errors++; $display("FAIL bp_req_low: got %b want 0", o_req); end
    id_ready = 1'b1;
    exp_addr = 32'h8; exp_pc = 32'h0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (o_gnt) begin
        checks++; if (o_addr !== exp_addr) begin errors++; $display("FAIL bp_resume_addr: got %h want %h", o_addr, exp_addr); end
        exp_addr = exp_addr + 32'd4;
      end
      if (o_take) begin
        checks++; if (o_pc !== exp_pc || o_instr !== mem_fn(exp_pc)) begin
          errors++; $display("FAIL bp_resume_data: pc %h instr %h want %h/%h", o_pc, o_instr, exp_pc, mem_fn(exp_pc)); end
        exp_pc = exp_pc + 32'd4;
      end
    end
    checks++; if (exp_pc < 32'd32) begin errors++; $display("FAIL bp_resume_count: next pc %h want >=00000020", exp_pc); end
  endtask

  task automatic test_redirect();
    logic [31:0] exp_addr, exp_pc;
    int stale;
    bit granted;
    do_reset();
    fetch_en = 1'b1; imem_gnt = 1'b1; id_ready = 1'b1; resp_en = 1'b0;
    for (int i = 0; i < 4; i++) step();
    checks++; if (pend.size() != 2) begin errors++; $display("FAIL redir_setup: got %0d outstanding want 2", pend.size()); end
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    step();
    checks++; if (o_req !== 1'b0) begin errors++; $display("FAIL redir_req_low: got %b want 0", o_req); end
    redirect = 1'b0; resp_en = 1'b1;
    exp_addr = 32'h100; exp_pc = 32'h100; stale = 0; granted = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (o_rvalid && !granted) stale++;
      if (o_gnt) begin
        granted = 1'b1;
        checks++; if (o_addr !== exp_addr) begin errors++; $display("FAIL redir_addr: got %h want %h", o_addr, exp_addr); end
        exp_addr = exp_addr + 32'd4;
      end
      if (o_take) begin
        checks++; if (o_pc !== exp_pc || o_instr !== mem_fn(exp_pc)) begin
          errors++; $display("FAIL redir_data: pc %h instr %h want %h/%h", o_pc, o_instr, exp_pc, mem_fn(exp_pc)); end
        exp_pc = exp_pc + 32'd4;
      end
    end
    checks++; if (stale != 2) begin errors++; $display("FAIL redir_stale: got %0d responses before new grant want 2", stale); end
    checks++; if (exp_pc < 32'h110) begin errors++; $display("FAIL redir_progress: next pc %h want >=00000110", exp_pc); end
  endtask

  task automatic test_gnt_stall();
    bit found;
    do_reset();
    fetch_en = 1'b1; imem_gnt = 1'b1; id_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (o_gnt && o_addr == 32'h8) begin found = 1'b1; break; end
    end
    checks++; if (!found) begin errors++; $display("FAIL stall_setup: got no grant at 00000008 want one"); end
    imem_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (o_req !== 1'b1 || o_addr !== 32'hC) begin
        errors++; $display("FAIL stall_hold: req %b addr %h want 1/0000000c", o_req, o_addr); end
    end
    imem_gnt = 1'b1;
    step();
    checks++; if (o_gnt !== 1'b1 || o_addr !== 32'hC) begin
      errors++; $display("FAIL stall_grant: gnt %b addr %h want 1/0000000c", o_gnt, o_addr); end
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (o_gnt) begin found = 1'b1; break; end
    end
    checks++; if (!found || o_addr !== 32'h10) begin
      errors++; $display("FAIL stall_next: found %b addr %h want 1/00000010", found, o_addr); end
  endtask

  task automatic test_async_reset();
    bit found;
    do_reset();
    fetch_en = 1'b1; imem_gnt = 1'b1; id_ready = 1'b0;
    for (int i = 0; i < 6; i++) step();
    id_ready = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b1 || id_valid !== 1'b1) begin
      errors++; $display("FAIL areset_pre: req %b valid %b want 1/1", imem_req, id_valid); end
    #1;
    reset_n = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0 || id_valid !== 1'b0) begin
      errors++; $display("FAIL areset_now: req %b valid %b want 0/0", imem_req, id_valid); end
    checks++; if (imem_addr !== 32'h0 || id_pc !== 32'h0) begin
      errors++; $display("FAIL areset_vals: addr %h pc %h want 0/0", imem_addr, id_pc); end
    imem_rvalid = 1'b0; imem_rdata = 32'h0;
    pend.delete();
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (o_gnt) begin found = 1'b1; break; end
    end
    checks++; if (!found || o_addr !== 32'h0) begin
      errors++; $display("FAIL areset_restart: found %b addr %h want 1/00000000", found, o_addr); end
    found = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (o_take) begin found = 1'b1; break; end
    end
    checks++; if (!found || o_pc !== 32'h0 || o_instr !== mem_fn(32'h0)) begin
      errors++; $display("FAIL areset_first: found %b pc %h instr %h want 1/00000000/%h", found, o_pc, o_instr, mem_fn(32'h0)); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_stream();
    test_backpressure();
    test_redirect();
    test_gnt_stall();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
